// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the in-order
//   pipeline writeback (A) and the long-latency writeback (B), and keeps a
//   busy scoreboard of destinations still owed by B so decode can stall.
//
// Optional feature macro: RV5STAGE_WB_STARVE_GUARD_EN
//   When defined, a saturating 8-bit wait counter forces a grant to B after
//   MAX_WAIT consecutive refused cycles. When undefined, A has strict
//   priority and B can starve.
//
// Parameters
//   MAX_WAIT     refused cycles before B is forced a grant (1..255)
// Ports
//   clk, rst                         clock, async active-high reset
//   a_valid/a_addr/a_data, a_ready   pipeline writeback request / accept
//   b_valid/b_addr/b_data, b_ready   long-latency writeback request / accept
//   issue_valid, issue_rd            long-latency op issued, its destination
//   chk_r1_addr/chk_r2_addr/chk_rd_addr  decode operands checked for hazards
//   stall                            decode must hold (combinational)
//   busy                             scoreboard, bit n = register n owed by B
//   w_enable/w_addr/w_data           registered register-file write port
module regfile_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  chk_r1_addr,
    input  logic [4:0]  chk_r2_addr,
    input  logic [4:0]  chk_rd_addr,
    output logic        stall,
    output logic [31:0] busy,
    output logic        w_enable,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data
);

    generate
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
            $error("regfile_wb_arbiter: MAX_WAIT must be within 1..255");
        end
    endgenerate

    logic        w_force_b;
    logic        w_a_xfer;
    logic        w_b_xfer;
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;
    logic [31:0] w_busy_next;

    logic [31:0] r_busy;
    logic        r_w_enable;
    logic [4:0]  r_w_addr;
    logic [31:0] r_w_data;

    // Handshakes are held low during reset so nothing is accepted while the
    // write port and scoreboard are being cleared.
    assign a_ready  = !rst && a_valid && !w_force_b;
    assign b_ready  = !rst && b_valid && !(a_valid && !w_force_b);
    assign w_a_xfer = a_valid && a_ready;
    assign w_b_xfer = b_valid && b_ready;

`ifdef RV5STAGE_WB_STARVE_GUARD_EN
    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0] r_wait;
    logic [7:0] w_wait_next;
    logic       r_force_b;

    always_comb begin
        w_wait_next = r_wait;
        if (w_b_xfer || !b_valid) begin
            w_wait_next = '0;
        end else if (r_wait != '1) begin
            w_wait_next = r_wait + 8'd1;
        end
    end

    // force_b is registered from the next counter value, so it is high in
    // the cycle right after the counter reaches MAX_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait    <= '0;
            r_force_b <= 1'b0;
        end else begin
            r_wait    <= w_wait_next;
            r_force_b <= (w_wait_next >= LP_MAX_WAIT);
        end
    end

    assign w_force_b = r_force_b;
`else
    assign w_force_b = 1'b0;
`endif

    // Set wins over clear on the same bit: the newly issued op owns it.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (issue_valid) begin
            w_busy_set[issue_rd] = 1'b1;
        end
        if (w_b_xfer) begin
            w_busy_clr[b_addr] = 1'b1;
        end
        w_busy_next    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_w_enable <= 1'b0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_a_xfer) begin
                r_w_enable <= (a_addr != 5'd0);
                r_w_addr   <= a_addr;
                r_w_data   <= a_data;
            end else if (w_b_xfer) begin
                r_w_enable <= (b_addr != 5'd0);
                r_w_addr   <= b_addr;
                r_w_data   <= b_data;
            end else begin
                r_w_enable <= 1'b0;
            end
        end
    end

    assign stall    = !rst && (r_busy[chk_r1_addr] | r_busy[chk_r2_addr] | r_busy[chk_rd_addr]);
    assign busy     = r_busy;
    assign w_enable = r_w_enable;
    assign w_addr   = r_w_addr;
    assign w_data   = r_w_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Inputs change on the falling
// edge; combinational outputs are sampled 1ns later and registered outputs
// 1ns after the rising edge.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_r1_addr;
    logic [4:0]  chk_r2_addr;
    logic [4:0]  chk_rd_addr;
    logic        stall;
    logic [31:0] busy;
    logic        w_enable;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_r1_addr (chk_r1_addr),
        .chk_r2_addr (chk_r2_addr),
        .chk_rd_addr (chk_rd_addr),
        .stall       (stall),
        .busy        (busy),
        .w_enable    (w_enable),
        .w_addr      (w_addr),
        .w_data      (w_data)
    );

    task automatic idle_inputs();
        a_valid     = 1'b0;
        a_addr      = '0;
        a_data      = '0;
        b_valid     = 1'b0;
        b_addr      = '0;
        b_data      = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        chk_r1_addr = '0;
        chk_r2_addr = '0;
        chk_rd_addr = '0;
    endtask

    task automatic after_rise();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst     = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_addr  = 5'd3;
        b_addr  = 5'd4;
        after_rise();
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=%h", busy, 32'h0); end
        total++; if (w_enable !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", w_enable); end
        total++; if (w_addr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", w_addr); end
        total++; if (w_data !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", w_data); end
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_b_ready got=%b exp=0", b_ready); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        after_rise();
    endtask

    task automatic test_a_write();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL a_write_ready got=%b exp=1", a_ready); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL a_write_b_ready got=%b exp=0", b_ready); end
        after_rise();
        total++; if (w_enable !== 1'b1) begin bad++; $display("FAIL a_write_wen got=%b exp=1", w_enable); end
        total++; if (w_addr !== 5'd5) begin bad++; $display("FAIL a_write_waddr got=%0d exp=5", w_addr); end
        total++; if (w_data !== 32'h0000_1234) begin bad++; $display("FAIL a_write_wdata got=%h exp=00001234", w_data); end
        @(negedge clk);
        idle_inputs();
        after_rise();
        total++; if (w_enable !== 1'b0) begin bad++; $display("FAIL a_idle_wen got=%b exp=0", w_enable); end
        total++; if (w_addr !== 5'd5) begin bad++; $display("FAIL a_idle_hold_addr got=%0d exp=5", w_addr); end
        total++; if (w_data !== 32'h0000_1234) begin bad++; $display("FAIL a_idle_hold_data got=%h exp=00001234", w_data); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd7;
        chk_r1_addr = 5'd7;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sb_no_comb_path got=%b exp=0", stall); end
        after_rise();
        @(negedge clk);
        issue_valid = 1'b0; issue_rd = '0;
        #1;
        total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_busy_set got=%h exp=00000080", busy); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_r1 got=%b exp=1", stall); end
        chk_r1_addr = 5'd0; chk_r2_addr = 5'd7;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_r2 got=%b exp=1", stall); end
        chk_r2_addr = 5'd0; chk_rd_addr = 5'd7;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_rd got=%b exp=1", stall); end
        chk_rd_addr = 5'd6;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sb_no_stall_other got=%b exp=0", stall); end
        chk_r1_addr = 5'd7;
        @(negedge clk);
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hCAFE;
        #1;
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL sb_b_ready got=%b exp=1", b_ready); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_before_clear got=%b exp=1", stall); end
        after_rise();
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL sb_busy_clear got=%h exp=0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sb_stall_clear got=%b exp=0", stall); end
        total++; if (w_enable !== 1'b1) begin bad++; $display("FAIL sb_b_wen got=%b exp=1", w_enable); end
        total++; if (w_addr !== 5'd7) begin bad++; $display("FAIL sb_b_waddr got=%0d exp=7", w_addr); end
        total++; if (w_data !== 32'h0000_CAFE) begin bad++; $display("FAIL sb_b_wdata got=%h exp=0000cafe", w_data); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_contention();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL cont_a_ready got=%b exp=1", a_ready); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL cont_b_ready got=%b exp=0", b_ready); end
        after_rise();
        total++; if (w_data !== 32'h11) begin bad++; $display("FAIL cont_a_wdata got=%h exp=00000011", w_data); end
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL cont_b_granted got=%b exp=1", b_ready); end
        after_rise();
        total++; if (w_data !== 32'h22) begin bad++; $display("FAIL cont_b_wdata got=%h exp=00000022", w_data); end
        total++; if (w_addr !== 5'd2) begin bad++; $display("FAIL cont_b_waddr got=%0d exp=2", w_addr); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_set_clear_same();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd3;
        after_rise();
        @(negedge clk);
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h33;
        #1;
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL same_b_ready got=%b exp=1", b_ready); end
        after_rise();
        total++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL same_set_wins got=%h exp=00000008", busy); end
        // B write to a register whose busy bit is clear: write proceeds, scoreboard untouched.
        @(negedge clk);
        issue_valid = 1'b0; issue_rd = '0;
        b_addr = 5'd9; b_data = 32'h99;
        after_rise();
        total++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL stray_b_busy got=%h exp=00000008", busy); end
        total++; if (w_enable !== 1'b1) begin bad++; $display("FAIL stray_b_wen got=%b exp=1", w_enable); end
        total++; if (w_addr !== 5'd9) begin bad++; $display("FAIL stray_b_waddr got=%0d exp=9", w_addr); end
        @(negedge clk);
        b_addr = 5'd3; b_data = 32'h3;
        after_rise();
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL same_cleanup got=%h exp=0", busy); end
        @(negedge clk);
        b_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        after_rise();
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL issue_x0 got=%h exp=0", busy); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addrs [3];
        logic [31:0] datas [3];
        addrs = '{5'd4, 5'd12, 5'd31};
        datas = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_valid = 1'b1; a_addr = addrs[i]; a_data = datas[i];
            after_rise();
            total++; if (w_enable !== 1'b1 || w_addr !== addrs[i] || w_data !== datas[i]) begin
                bad++;
                $display("FAIL b2b_%0d got=%b/%0d/%h exp=1/%0d/%h", i, w_enable, w_addr, w_data, addrs[i], datas[i]);
            end
        end
        @(negedge clk);
        a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL x0_a_ready got=%b exp=1", a_ready); end
        after_rise();
        total++; if (w_enable !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b exp=0", w_enable); end
        @(negedge clk);
        idle_inputs();
        after_rise();
    endtask

    task automatic test_starvation();
        bit exp_b;
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd20; a_data = 32'hAAAA;
        b_valid = 1'b1; b_addr = 5'd21; b_data = 32'hBBBB;
        for (int i = 0; i < 10; i++) begin
`ifdef RV5STAGE_WB_STARVE_GUARD_EN
            exp_b = ((i % 5) == 4);
`else
            exp_b = 1'b0;
`endif
            #1;
            total++; if (a_ready !== !exp_b || b_ready !== exp_b) begin
                bad++;
                $display("FAIL starve_cycle_%0d got a=%b b=%b exp a=%b b=%b", i, a_ready, b_ready, !exp_b, exp_b);
            end
            after_rise();
            total++; if (w_data !== (exp_b ? 32'hBBBB : 32'hAAAA)) begin
                bad++;
                $display("FAIL starve_wdata_%0d got=%h exp=%h", i, w_data, exp_b ? 32'hBBBB : 32'hAAAA);
            end
            @(negedge clk);
        end
        idle_inputs();
        after_rise();
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd12;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h5555;
        chk_r1_addr = 5'd12;
        after_rise();
        total++; if (busy !== 32'h0000_1000 || w_enable !== 1'b1) begin
            bad++; $display("FAIL midrun_setup got busy=%h wen=%b exp busy=00001000 wen=1", busy, w_enable);
        end
        issue_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL midrun_busy got=%h exp=0", busy); end
        total++; if (w_enable !== 1'b0) begin bad++; $display("FAIL midrun_wen got=%b exp=0", w_enable); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL midrun_stall got=%b exp=0", stall); end
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL midrun_a_ready got=%b exp=0", a_ready); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        after_rise();
        total++; if (busy !== 32'h0 || w_enable !== 1'b0) begin
            bad++; $display("FAIL midrun_after got busy=%h wen=%b exp 0/0", busy, w_enable);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_a_write();
        test_scoreboard();
        test_contention();
        test_set_clear_same();
        test_back_to_back();
        test_starvation();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
